// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D-cache main-memory arbiter.
// Build with ARB_RR_EN defined for round-robin tie breaking.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/cache_arb_sel.sv
// Winner select between I-cache and D-cache requests.
// ARB_RR_EN: a tie goes to the side that lost the previous grant.
module cache_arb_sel
  import cache_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   last_winner,
  output owner_t winner
);

  logic dOnTie;

`ifdef ARB_RR_EN
  assign dOnTie = ~last_winner;
`else
  // fixed D-over-I: the last winner never matters
  assign dOnTie = 1'b1 | last_winner;
`endif

  always_comb begin
    winner = OWN_NONE;
    if (d_req && (!i_req || dOnTie)) begin
      winner = OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache and D-cache miss paths,
// one operation at a time. ARB_RR_EN enables round-robin ties.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_stall,
  output logic          busy,
  output logic [1:0]    owner
);

  arb_state_t       state, stateNext;
  owner_t           curOwner, grant;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [AW-1:0]    latAddr;
  logic [DW-1:0]    latWdata;
  logic             latWr;
  logic             lastWinner;
  logic             granting;

  cache_arb_sel uSel (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_winner(lastWinner),
    .winner     (grant)
  );

  assign granting = (state == IDLE) && (grant != OWN_NONE);

`ifdef ARB_RR_EN
  // 1 = D-cache took the last grant
  always_ff @(posedge clk) begin
    if (rst) begin
      lastWinner <= 1'b0;
    end else if (granting) begin
      lastWinner <= (grant == OWN_D);
    end
  end
`else
  assign lastWinner = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (grant != OWN_NONE) stateNext = ISSUE;
      end
      ISSUE: begin
        if (!mem_stall) begin
          stateNext = WAIT;
          cntNext   = CNT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) stateNext = RESP;
        else cntNext = cnt - 1'b1;
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      curOwner <= OWN_NONE;
      latAddr  <= '0;
      latWdata <= '0;
      latWr    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (granting) begin
        curOwner <= grant;
        latAddr  <= (grant == OWN_D) ? d_addr : i_addr;
        latWdata <= (grant == OWN_D) ? d_wdata : '0;
        latWr    <= (grant == OWN_D) && d_wr;
      end
      // captured data becomes visible in the RESP cycle
      if (state == WAIT && cnt == '0 && !latWr) begin
        if (curOwner == OWN_I) i_rdata <= mem_rdata;
        else d_rdata <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign owner     = busy ? curOwner : OWN_NONE;
  assign mem_en    = (state == ISSUE);
  assign mem_wr    = mem_en && latWr;
  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;
  assign i_done    = (state == RESP) && (curOwner == OWN_I);
  assign d_done    = (state == RESP) && (curOwner == OWN_D);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed timing cases
// plus randomized I/D traffic against a simple memory model.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int MEM_LAT = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_stall = 1'b0;
  logic          busy;
  logic [1:0]    owner;

  cache_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic failMsg(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [15:0] initVal(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  // memory model: drives inputs 1 time unit after each posedge
  logic [15:0] memArr [int];
  logic [15:0] rdVal = '0;
  int rdCnt = -1;
  int accepts = 0;
  int stallPct = 0;
  int stallFrom = -1;
  int stallTo = -1;

  always begin
    @(posedge clk);
    #1;
    if (rdCnt > 0) rdCnt--;
    mem_rdata = (rdCnt == 0) ? rdVal : 16'($urandom);
    if (rdCnt == 0) rdCnt = -1;
    mem_stall = (cyc >= stallFrom && cyc <= stallTo) ||
                ($urandom_range(99) < stallPct);
    if (mem_en && !mem_stall) begin
      accepts++;
      if (mem_wr) begin
        memArr[int'(mem_addr)] = mem_wdata;
      end else begin
        rdVal = memArr.exists(int'(mem_addr)) ?
                memArr[int'(mem_addr)] : initVal(mem_addr);
        rdCnt = MEM_LAT;
      end
    end
  end

  // scoreboard monitor, sampling on the falling edge
  typedef struct {
    logic        wr;
    logic [15:0] data;
  } dexp_t;

  logic [15:0] iExpQ [$];
  dexp_t       dExpQ [$];
  logic        lastD = 1'b0;
  logic        ownPend = 1'b0;
  logic [1:0]  ownExp = 2'b00;

  function automatic logic [1:0] pickOwner(input logic ir, input logic dr,
                                           input logic ld);
    if (ir && dr) return (RR && ld) ? OWN_I : OWN_D;
    return dr ? OWN_D : OWN_I;
  endfunction

  always @(negedge clk) begin
    dexp_t e;
    if (ownPend) chk("owner_grant", owner, ownExp);
    ownPend = 1'b0;
    if (rst) begin
      lastD = 1'b0;
    end else if (!busy && (i_req || d_req)) begin
      ownExp  = pickOwner(i_req, d_req, lastD);
      lastD   = (ownExp == OWN_D);
      ownPend = 1'b1;
    end
    if (i_done) begin
      if (iExpQ.size() == 0) failMsg("i_spurious_done");
      else chk("i_rdata", i_rdata, iExpQ.pop_front());
    end
    if (d_done) begin
      if (dExpQ.size() == 0) begin
        failMsg("d_spurious_done");
      end else begin
        e = dExpQ.pop_front();
        if (!e.wr) chk("d_rdata", d_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input bit isD, output int at);
    at = -1;
    for (int n = 0; n < 100; n++) begin
      if (isD ? d_done : i_done) begin
        at = cyc;
        return;
      end
      tick();
    end
    failMsg(isD ? "d_done_timeout" : "i_done_timeout");
  endtask

  // random-phase wait: may drop or scramble inputs after grant
  task automatic reqWait(input bit isD);
    int n;
    n = 0;
    while (!(isD ? d_done : i_done)) begin
      if (n == 300) begin
        failMsg(isD ? "d_req_timeout" : "i_req_timeout");
        return;
      end
      n++;
      tick();
      if (owner == (isD ? OWN_D : OWN_I) && $urandom_range(3) == 0) begin
        if (isD) begin
          d_req = 1'b0;
          d_wr = 1'($urandom);
          d_addr = 16'($urandom);
          d_wdata = 16'($urandom);
        end else begin
          i_req = 1'b0;
          i_addr = 16'($urandom);
        end
      end
    end
  endtask

  logic [15:0] refD [int];
  int nTx = 0;

  task automatic iLoop();
    logic [15:0] a;
    for (int k = 0; k < 50; k++) begin
      repeat ($urandom_range(3)) tick();
      a = {1'b0, 15'($urandom)};
      i_addr = a;
      i_req = 1'b1;
      iExpQ.push_back(initVal(a));
      nTx++;
      reqWait(1'b0);
      tick();
      i_req = 1'b0;
    end
  endtask

  task automatic dLoop();
    logic [15:0] a;
    logic [15:0] wd;
    logic        wr;
    for (int k = 0; k < 50; k++) begin
      repeat ($urandom_range(3)) tick();
      a  = {11'h400, 5'($urandom)};
      wd = 16'($urandom);
      wr = 1'($urandom);
      if (wr) begin
        refD[int'(a)] = wd;
        dExpQ.push_back('{1'b1, 16'h0000});
      end else begin
        dExpQ.push_back('{1'b0, refD.exists(int'(a)) ?
                                refD[int'(a)] : initVal(a)});
      end
      d_addr = a;
      d_wdata = wd;
      d_wr = wr;
      d_req = 1'b1;
      nTx++;
      reqWait(1'b1);
      tick();
      d_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int c0, t, wrCyc, nd, acc0;
    logic [3:0] seq;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_done", {i_done, d_done}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_mem_bus", {mem_wr, mem_addr, mem_wdata}, 0);
    rst = 1'b0;

    // single I read
    memArr[int'(16'h0040)] = 16'hBEEF;
    tick();
    c0 = cyc;
    i_req = 1'b1;
    i_addr = 16'h0040;
    iExpQ.push_back(16'hBEEF);
    tick();
    i_addr = 16'h1111;
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 16'h0040);
    chk("t1_owner", owner, OWN_I);
    waitDone(1'b0, t);
    chk("t1_latency", t - c0, MEM_LAT + 2);
    tick();
    i_req = 1'b0;

    // simultaneous requests: D first, then I
    memArr[int'(16'h0100)] = 16'hCAFE;
    tick();
    c0 = cyc;
    i_req = 1'b1;
    i_addr = 16'h0040;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0100;
    iExpQ.push_back(16'hBEEF);
    dExpQ.push_back('{1'b0, 16'hCAFE});
    waitDone(1'b1, t);
    chk("t2_d_latency", t - c0, MEM_LAT + 2);
    tick();
    d_req = 1'b0;
    waitDone(1'b0, t);
    chk("t2_i_latency", t - c0, 2 * MEM_LAT + 5);
    tick();
    i_req = 1'b0;

    // stalled write
    tick();
    c0 = cyc;
    stallFrom = c0 + 1;
    stallTo = c0 + 3;
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0200;
    d_wdata = 16'h1234;
    dExpQ.push_back('{1'b1, 16'h0000});
    wrCyc = 0;
    t = -1;
    for (int k = 0; k < 100 && t < 0; k++) begin
      tick();
      if (mem_en && mem_wr) wrCyc++;
      if (d_done) t = cyc;
    end
    if (t < 0) failMsg("t3_timeout");
    chk("t3_latency", t - c0, MEM_LAT + 5);
    chk("t3_wr_cycles", wrCyc, 4);
    chk("t3_mem_data", memArr.exists(int'(16'h0200)) ?
        memArr[int'(16'h0200)] : 16'hxxxx, 16'h1234);
    tick();
    d_req = 1'b0;
    stallFrom = -1;
    stallTo = -1;

    // reset in the middle of an I read
    tick();
    i_req = 1'b1;
    i_addr = 16'h0040;
    iExpQ.push_back(16'hBEEF);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req = 1'b0;
    iExpQ.delete();
    chk("t4_busy", busy, 0);
    chk("t4_owner", owner, 0);
    chk("t4_mem", {mem_en, mem_wr, mem_addr}, 0);
    chk("t4_done", {i_done, d_done}, 0);
    chk("t4_rdata", {i_rdata, d_rdata}, 0);
    tick();
    c0 = cyc;
    i_req = 1'b1;
    i_addr = 16'h0080;
    iExpQ.push_back(initVal(16'h0080));
    waitDone(1'b0, t);
    chk("t4_latency", t - c0, MEM_LAT + 2);
    tick();
    i_req = 1'b0;

    // both held for four grants
    tick();
    i_req = 1'b1;
    i_addr = 16'h0040;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0100;
    repeat (4) begin
      iExpQ.push_back(16'hBEEF);
      dExpQ.push_back('{1'b0, 16'hCAFE});
    end
    seq = '0;
    nd = 0;
    for (int k = 0; k < 200 && nd < 4; k++) begin
      tick();
      if (i_done || d_done) begin
        seq = {seq[2:0], d_done};
        nd++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("t5_grant_seq", seq, RR ? 4'b1010 : 4'b1111);
    tick();
    iExpQ.delete();
    dExpQ.delete();
    repeat (2) tick();

    // randomized traffic
    memArr.delete();
    refD.delete();
    stallPct = 25;
    acc0 = accepts;
    fork
      iLoop();
      dLoop();
    join
    repeat (3) tick();
    chk("rand_issue_count", accepts - acc0, nTx);
    chk("rand_queues_empty", iExpQ.size() + dExpQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
